// File: rtl/tx_requests_arbiter_pkg.sv
// Shared TX protocol constants: source headers, FSM states, grant codes.
// Imported by the request latch and the TX arbiter.
package tx_protocol_defines;

  localparam logic [7:0] HDR_CH1  = 8'h31;
  localparam logic [7:0] HDR_CH2  = 8'h32;
  localparam logic [7:0] HDR_TRIG = 8'h54;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GNT_TRIG = 2'd0,
    GNT_CH1  = 2'd1,
    GNT_CH2  = 2'd2
  } gnt_t;

  function automatic logic [7:0] hdr_of(input gnt_t g);
    logic [7:0] h;
    h = HDR_CH2;
    unique case (g)
      GNT_TRIG: h = HDR_TRIG;
      GNT_CH1:  h = HDR_CH1;
      default:  h = HDR_CH2;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/tx_requests_arbiter_request_latch.sv
// Pending request flags and fixed trig > ch1 > ch2 priority encoder.
// A request landing on its own grant cycle keeps the flag set.
module request_latch
  import tx_protocol_defines::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic rqst_trig,
  input  logic rqst_ch1,
  input  logic rqst_ch2,
  input  logic take,
  output logic any_pending,
  output gnt_t grant_sel
);

  logic pend_trig;
  logic pend_ch1;
  logic pend_ch2;
  logic clr_trig;
  logic clr_ch1;
  logic clr_ch2;

  assign clr_trig = take && (grant_sel == GNT_TRIG);
  assign clr_ch1  = take && (grant_sel == GNT_CH1);
  assign clr_ch2  = take && (grant_sel == GNT_CH2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_trig <= 1'b0;
      pend_ch1  <= 1'b0;
      pend_ch2  <= 1'b0;
    end else if (clear) begin
      pend_trig <= 1'b0;
      pend_ch1  <= 1'b0;
      pend_ch2  <= 1'b0;
    end else begin
      pend_trig <= (pend_trig & ~clr_trig) | rqst_trig;
      pend_ch1  <= (pend_ch1 & ~clr_ch1) | rqst_ch1;
      pend_ch2  <= (pend_ch2 & ~clr_ch2) | rqst_ch2;
    end
  end

  assign any_pending = pend_trig | pend_ch1 | pend_ch2;

  always_comb begin
    grant_sel = GNT_CH2;
    priority case (1'b1)
      pend_trig: grant_sel = GNT_TRIG;
      pend_ch1:  grant_sel = GNT_CH1;
      default:   grant_sel = GNT_CH2;
    endcase
  end

endmodule

// File: rtl/tx_requests_arbiter.sv
// Shares the UART TX port between ch1, ch2 and trigger status sources.
// Each grant sends a source header, then the payload, then releases TX.
module tx_requests_arbiter
  import tx_protocol_defines::*;
#(
  parameter int TX_DATA_WIDTH     = 8,
  parameter int CH_BURST_LEN      = 64,
  parameter int TRIG_STATUS_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear_i,
  input  logic                         rqst_ch1,
  input  logic                         rqst_ch2,
  input  logic                         rqst_trigger_status,
  input  logic [TX_DATA_WIDTH-1:0]     ch1_data,
  input  logic                         ch1_rdy,
  output logic                         ch1_ack,
  input  logic [TX_DATA_WIDTH-1:0]     ch2_data,
  input  logic                         ch2_rdy,
  output logic                         ch2_ack,
  input  logic [TRIG_STATUS_WIDTH-1:0] trig_status,
  output logic [TX_DATA_WIDTH-1:0]     tx_data,
  output logic                         tx_rdy,
  input  logic                         tx_ack,
  output logic                         busy_o
);

  localparam int CW = $clog2(CH_BURST_LEN + 1);

  state_t                   state;
  state_t                   state_nx;
  gnt_t                     gnt;
  gnt_t                     grant_sel;
  logic                     any_pending;
  logic                     take;
  logic                     xfer;
  logic                     last;
  logic [CW-1:0]            cnt;
  logic [TX_DATA_WIDTH-1:0] trig_q;

  assign take = (state == ST_IDLE) && any_pending && !clear_i;
  assign xfer = tx_rdy & tx_ack;
  assign last = (cnt == CW'(1));

  request_latch u_req (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear_i),
    .rqst_trig   (rqst_trigger_status),
    .rqst_ch1    (rqst_ch1),
    .rqst_ch2    (rqst_ch2),
    .take        (take),
    .any_pending (any_pending),
    .grant_sel   (grant_sel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (clear_i) begin
      state_nx = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:    if (any_pending) state_nx = ST_HEADER;
        ST_HEADER:  if (xfer) state_nx = ST_PAYLOAD;
        ST_PAYLOAD: if (xfer && last) state_nx = ST_IDLE;
        default:    state_nx = ST_IDLE;
      endcase
    end
  end

  // Trig bursts load 1 so every grant exits the payload on the same rule.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt    <= GNT_TRIG;
      cnt    <= '0;
      trig_q <= '0;
    end else if (clear_i) begin
      cnt <= '0;
    end else begin
      if (take) begin
        gnt <= grant_sel;
        cnt <= (grant_sel == GNT_TRIG) ? CW'(1) : CW'(CH_BURST_LEN);
      end
      if (state == ST_HEADER && xfer)
        trig_q <= TX_DATA_WIDTH'(trig_status);
      if (state == ST_PAYLOAD && xfer)
        cnt <= cnt - CW'(1);
    end
  end

  always_comb begin
    tx_rdy  = 1'b0;
    tx_data = '0;
    ch1_ack = 1'b0;
    ch2_ack = 1'b0;
    busy_o  = (state != ST_IDLE);
    unique case (state)
      ST_HEADER: begin
        tx_rdy  = 1'b1;
        tx_data = TX_DATA_WIDTH'(hdr_of(gnt));
      end
      ST_PAYLOAD: begin
        unique case (gnt)
          GNT_CH1: begin
            tx_rdy  = ch1_rdy;
            tx_data = ch1_data;
            ch1_ack = tx_ack & ch1_rdy;
          end
          GNT_CH2: begin
            tx_rdy  = ch2_rdy;
            tx_data = ch2_data;
            ch2_ack = tx_ack & ch2_rdy;
          end
          default: begin
            tx_rdy  = 1'b1;
            tx_data = trig_q;
          end
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tx_requests_arbiter.sv
// Directed bench for tx_requests_arbiter with a TX word scoreboard.
// Burst length is 4; the UART model acks every third cycle.
module tb_tx_requests_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear_i;
  logic       rqst_ch1;
  logic       rqst_ch2;
  logic       rqst_trigger_status;
  logic [7:0] ch1_data;
  logic       ch1_rdy;
  logic       ch1_ack;
  logic [7:0] ch2_data;
  logic       ch2_rdy;
  logic       ch2_ack;
  logic [7:0] trig_status;
  logic [7:0] tx_data;
  logic       tx_rdy;
  logic       tx_ack;
  logic       busy_o;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int busy_drops = 0;
  int busy_hi = 0;
  int ch2_ack_hi = 0;
  logic busy_prev = 1'b0;

  logic [7:0] ch1_idx = 8'h00;
  logic [7:0] ch2_idx = 8'h00;
  logic [7:0] ch1_exp = 8'hA0;
  logic [7:0] ch2_exp = 8'hC0;
  logic [7:0] sb[$];

  tx_requests_arbiter #(
    .TX_DATA_WIDTH     (8),
    .CH_BURST_LEN      (4),
    .TRIG_STATUS_WIDTH (8)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .clear_i             (clear_i),
    .rqst_ch1            (rqst_ch1),
    .rqst_ch2            (rqst_ch2),
    .rqst_trigger_status (rqst_trigger_status),
    .ch1_data            (ch1_data),
    .ch1_rdy             (ch1_rdy),
    .ch1_ack             (ch1_ack),
    .ch2_data            (ch2_data),
    .ch2_rdy             (ch2_rdy),
    .ch2_ack             (ch2_ack),
    .trig_status         (trig_status),
    .tx_data             (tx_data),
    .tx_rdy              (tx_rdy),
    .tx_ack              (tx_ack),
    .busy_o              (busy_o)
  );

  always #5 clk = ~clk;

  assign tx_ack   = (cyc % 3) == 2;
  assign ch1_data = 8'hA0 + ch1_idx;
  assign ch2_data = 8'hC0 + ch2_idx;

  // Source models advance only when the DUT acknowledges a word.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ch1_ack) ch1_idx <= ch1_idx + 8'd1;
    if (ch2_ack) ch2_idx <= ch2_idx + 8'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] e;
    if (busy_prev && !busy_o) busy_drops++;
    busy_prev = busy_o;
    if (busy_o) busy_hi++;
    if (ch2_ack) ch2_ack_hi++;
    if (ch1_ack || ch2_ack) check("ack_excl", ch1_ack & ch2_ack, 0);
    if (tx_rdy === 1'b1 && tx_ack === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL unexpected_tx: got %0h want none", tx_data);
      end else begin
        e = sb.pop_front();
        check("tx_word", tx_data, e);
      end
    end
  end

  task automatic push_ch(input bit is_ch2);
    if (is_ch2) sb.push_back(8'h32);
    else        sb.push_back(8'h31);
    for (int i = 0; i < 4; i++) begin
      if (is_ch2) begin
        sb.push_back(ch2_exp);
        ch2_exp = ch2_exp + 8'd1;
      end else begin
        sb.push_back(ch1_exp);
        ch1_exp = ch1_exp + 8'd1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (sb.size() == 0 && !busy_o) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, ok, 1);
  endtask

  task automatic wait_q(input int n, input int budget, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (sb.size() <= n) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, ok, 1);
  endtask

  initial begin
    int d0;
    int h0;
    int a0;
    logic [7:0] i0;
    rst = 1'b1;
    clear_i = 1'b0;
    rqst_ch1 = 1'b0;
    rqst_ch2 = 1'b0;
    rqst_trigger_status = 1'b0;
    ch1_rdy = 1'b1;
    ch2_rdy = 1'b1;
    trig_status = 8'h00;
    repeat (3) step();
    check("rst_tx_rdy", tx_rdy, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy_o, 0);
    check("rst_ch1_ack", ch1_ack, 0);
    check("rst_ch2_ack", ch2_ack, 0);
    rst = 1'b0;
    repeat (2) step();
    check("idle_busy", busy_o, 0);

    // single ch1 burst and request-to-tx_rdy latency
    a0 = ch2_ack_hi;
    push_ch(1'b0);
    rqst_ch1 = 1'b1;
    step();
    rqst_ch1 = 1'b0;
    check("lat_n1_rdy", tx_rdy, 0);
    step();
    check("lat_n2_rdy", tx_rdy, 1);
    check("lat_n2_hdr", tx_data, 8'h31);
    check("lat_n2_busy", busy_o, 1);
    wait_idle(200, "ch1_done");
    check("ch1_busy_after", busy_o, 0);
    check("ch1_no_ch2_ack", ch2_ack_hi - a0, 0);

    // trig and ch2 in the same cycle: trig goes first
    d0 = busy_drops;
    trig_status = 8'h5A;
    sb.push_back(8'h54);
    sb.push_back(8'h5A);
    push_ch(1'b1);
    rqst_ch2 = 1'b1;
    rqst_trigger_status = 1'b1;
    step();
    rqst_ch2 = 1'b0;
    rqst_trigger_status = 1'b0;
    wait_idle(300, "trig_ch2_done");
    check("trig_ch2_gap", busy_drops - d0, 2);

    // ch1 re-armed mid-burst beats a later ch2 request
    d0 = busy_drops;
    push_ch(1'b0);
    push_ch(1'b0);
    push_ch(1'b1);
    rqst_ch1 = 1'b1;
    step();
    rqst_ch1 = 1'b0;
    wait_q(13, 100, "rearm_mid");
    rqst_ch1 = 1'b1;
    rqst_ch2 = 1'b1;
    step();
    rqst_ch1 = 1'b0;
    rqst_ch2 = 1'b0;
    wait_idle(500, "rearm_done");
    check("rearm_bursts", busy_drops - d0, 3);

    // source stall after the second payload word
    i0 = ch1_idx;
    push_ch(1'b0);
    rqst_ch1 = 1'b1;
    step();
    rqst_ch1 = 1'b0;
    wait_q(2, 100, "stall_pre");
    ch1_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_tx_rdy", tx_rdy, 0);
      check("stall_ack", ch1_ack, 0);
    end
    step();
    ch1_rdy = 1'b1;
    wait_idle(200, "stall_done");
    check("stall_words", 8'(ch1_idx - i0), 4);

    // clear_i after two payload words drops pending ch2/trig
    sb.push_back(8'h31);
    for (int i = 0; i < 2; i++) begin
      sb.push_back(ch1_exp);
      ch1_exp = ch1_exp + 8'd1;
    end
    rqst_ch1 = 1'b1;
    step();
    rqst_ch1 = 1'b0;
    step();
    rqst_ch2 = 1'b1;
    rqst_trigger_status = 1'b1;
    step();
    rqst_ch2 = 1'b0;
    rqst_trigger_status = 1'b0;
    wait_q(0, 100, "clr_pre");
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    check("clr_tx_rdy", tx_rdy, 0);
    check("clr_busy", busy_o, 0);
    check("clr_tx_data", tx_data, 0);
    h0 = busy_hi;
    repeat (20) step();
    check("clr_quiet", busy_hi - h0, 0);

    // async reset in HEADER acts without a clock edge
    rqst_ch2 = 1'b1;
    step();
    rqst_ch2 = 1'b0;
    step();
    check("arst_in_hdr", busy_o, 1);
    #1 rst = 1'b1;
    #1;
    check("arst_tx_rdy", tx_rdy, 0);
    check("arst_busy", busy_o, 0);
    repeat (2) step();
    rst = 1'b0;
    h0 = busy_hi;
    repeat (20) step();
    check("arst_quiet", busy_hi - h0, 0);
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
